regfile_wr_sched: RTL and testbench

- Owns the single write port (WE3/A3/WD3) of the 32x32 register file.
- After reset, runs an init sequence that writes zero to all 32 registers, because the array itself has no reset.
- Then shares the port between NREQ writeback requesters (ALU, load, mul/div) using round-robin arbitration with valid/ready handshakes.
- Never writes a non-zero value to register 0.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_wr_sched_rr_arbiter.sv | 28 ++
 rtl/regfile_wr_sched.sv | 90 +++++++++
 tb/tb_regfile_wr_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file write-port scheduler.
package regfile_pkg;
  localparam int REG_AW  = 5;
  localparam int REG_DW  = 32;
  localparam int NREG    = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic {INIT, RUN} state_t;

  // Requester ports are zero-extended to MAX_REQ lanes before slicing
  function automatic logic [REG_AW-1:0] addr_slice(input logic [MAX_REQ*REG_AW-1:0] v,
                                                   input int i);
    return v[i*REG_AW +: REG_AW];
  endfunction

  function automatic logic [REG_DW-1:0] data_slice(input logic [MAX_REQ*REG_DW-1:0] v,
                                                   input int i);
    return v[i*REG_DW +: REG_DW];
  endfunction
endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after ptr.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && valid[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/regfile_wr_sched.sv
// Owns the register-file write port: zero-init after reset, then round-robin
// sharing among writeback requesters with a one-cycle registered write.
import regfile_pkg::*;

module regfile_wr_sched #(
  parameter int NREQ    = 3,
  parameter bit INIT_EN = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*REG_AW-1:0]   req_addr,
  input  logic [NREQ*REG_DW-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     WE3,
  output logic [REG_AW-1:0]        A3,
  output logic [REG_DW-1:0]        WD3,
  output logic                     init_done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t                     state;
  logic [5:0]                 cnt;
  logic [PW-1:0]              rr_ptr;
  logic [PW-1:0]              next_ptr;
  logic [PW-1:0]              gnt_idx;
  logic [NREQ-1:0]            gnt;
  logic                       xfer;
  logic [MAX_REQ*REG_AW-1:0]  addr_all;
  logic [MAX_REQ*REG_DW-1:0]  data_all;
  logic [REG_AW-1:0]          sel_addr;
  logic [REG_DW-1:0]          sel_data;
  int                         nxt;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .valid   (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign addr_all  = (MAX_REQ*REG_AW)'(req_addr);
  assign data_all  = (MAX_REQ*REG_DW)'(req_data);
  assign sel_addr  = addr_slice(addr_all, int'(gnt_idx));
  assign sel_data  = data_slice(data_all, int'(gnt_idx));
  assign req_ready = (state == RUN) ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    nxt      = (int'(gnt_idx) + 1) % NREQ;
    next_ptr = nxt[PW-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= INIT_EN ? INIT : RUN;
      cnt       <= '0;
      rr_ptr    <= '0;
      WE3       <= 1'b0;
      A3        <= '0;
      WD3       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          WE3 <= 1'b1;
          A3  <= cnt[REG_AW-1:0];
          WD3 <= '0;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(NREG - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          init_done <= 1'b1;
          if (xfer) begin
            // Register 0 is hardwired: accept the request but suppress the write
            WE3    <= (sel_addr != '0);
            A3     <= sel_addr;
            WD3    <= sel_data;
            rr_ptr <= next_ptr;
          end else begin
            WE3 <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Randomized self-checking bench for regfile_wr_sched (NREQ=3, INIT_EN=1).
module tb_regfile_wr_sched;
  localparam int N = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [N-1:0]  req_valid;
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          WE3;
  logic [4:0]    A3;
  logic [31:0]   WD3;
  logic          init_done;

  int compared = 0;
  int mismatched = 0;

  // Requester-side pending transactions
  logic        v [N];
  logic [4:0]  a [N];
  logic [31:0] d [N];

  // Reference model state
  int          m_ptr;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  bit          m_known;
  int          last_grant;

  regfile_wr_sched #(.NREQ(N), .INIT_EN(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .WE3(WE3), .A3(A3), .WD3(WD3),
    .init_done(init_done)
  );

  always #5 CLK = ~CLK;

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = v[i];
      req_addr[i*5 +: 5]  = a[i];
      req_data[i*32 +: 32] = d[i];
    end
  endtask

  task automatic new_req(input int i, input bit allow_zero);
    v[i] = 1'b1;
    a[i] = allow_zero ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
    d[i] = $urandom;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
    apply();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    m_ptr = 0; m_a3 = '0; m_wd3 = '0; m_known = 1'b1; last_grant = -1;
  endtask

  // One RUN cycle: predict grant from the round-robin rule, check ready,
  // then check the registered write one edge later. Called at posedge+1.
  task automatic run_cycle(input string tag);
    int g;
    logic [N-1:0] exp_ready;
    bit exp_we;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i] && g < 0) g = i;
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    #1;
    compared++;
    if (req_ready !== exp_ready) begin
      mismatched++;
      $display("FAIL %s ready: got %b expected %b", tag, req_ready, exp_ready);
    end
    @(posedge CLK); #1;
    if (g >= 0) begin
      exp_we = (a[g] != 5'd0);
      m_known = exp_we;
      m_a3 = a[g]; m_wd3 = d[g];
      m_ptr = (g + 1) % N;
      v[g] = 1'b0;
    end else begin
      exp_we = 1'b0;
    end
    last_grant = g;
    compared++;
    if (WE3 !== exp_we) begin
      mismatched++;
      $display("FAIL %s WE3: got %b expected %b", tag, WE3, exp_we);
    end
    if (m_known) begin
      compared++;
      if (A3 !== m_a3 || WD3 !== m_wd3) begin
        mismatched++;
        $display("FAIL %s A3/WD3: got %0d/%h expected %0d/%h", tag, A3, WD3, m_a3, m_wd3);
      end
    end
    apply();
  endtask

  task automatic check_init_seq(input int edges);
    for (int k = 1; k <= edges; k++) begin
      compared++;
      if (req_ready !== '0) begin
        mismatched++;
        $display("FAIL init ready edge %0d: got %b expected 000", k, req_ready);
      end
      @(posedge CLK); #1;
      compared++;
      if (WE3 !== 1'b1 || A3 !== 5'(k - 1) || WD3 !== 32'd0 || init_done !== (k == 32)) begin
        mismatched++;
        $display("FAIL init edge %0d: got we=%b a=%0d wd=%h done=%b expected we=1 a=%0d wd=0 done=%b",
                 k, WE3, A3, WD3, init_done, k - 1, (k == 32));
      end
    end
  endtask

  task automatic test_reset();
    clear_reqs();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    compared++;
    if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0 || init_done !== 1'b0 || req_ready !== '0) begin
      mismatched++;
      $display("FAIL reset state: got we=%b a=%0d wd=%h done=%b rdy=%b expected all zero",
               WE3, A3, WD3, init_done, req_ready);
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < N; i++) new_req(i, 1'b0);
    apply();
    do_reset();
    check_init_seq(32);
    run_cycle("first_write");
    compared++;
    if (last_grant !== 0) begin
      mismatched++;
      $display("FAIL first_grant: got %0d expected 0", last_grant);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 2 * N; c++) begin
      if (v[0] || v[1] || v[2]) run_cycle("drain");
    end
  endtask

  task automatic test_round_robin();
    int exp_g;
    drain();
    clear_reqs();
    do_reset();
    check_init_seq(32);
    for (int i = 0; i < N; i++) new_req(i, 1'b0);
    apply();
    for (int c = 0; c < 6; c++) begin
      run_cycle("rr");
      exp_g = c % N;
      compared++;
      if (last_grant !== exp_g) begin
        mismatched++;
        $display("FAIL rr grant %0d: got %0d expected %0d", c, last_grant, exp_g);
      end
      new_req(last_grant < 0 ? 0 : last_grant, 1'b0);
      apply();
    end
  endtask

  task automatic test_addr0();
    drain();
    v[1] = 1'b1; a[1] = 5'd0; d[1] = 32'hDEADBEEF;
    apply();
    run_cycle("addr0");
    compared++;
    if (last_grant !== 1 || WE3 !== 1'b0) begin
      mismatched++;
      $display("FAIL addr0: got grant=%0d we=%b expected grant=1 we=0", last_grant, WE3);
    end
    for (int i = 0; i < N; i++) new_req(i, 1'b0);
    apply();
    run_cycle("addr0_ptr");
    compared++;
    if (last_grant !== 2) begin
      mismatched++;
      $display("FAIL addr0_ptr: got grant %0d expected 2", last_grant);
    end
  endtask

  task automatic test_contention();
    bit got;
    drain();
    got = 1'b0;
    new_req(0, 1'b0); new_req(1, 1'b0);
    v[2] = 1'b1; a[2] = 5'd5; d[2] = 32'h12345678;
    apply();
    for (int c = 0; c < N && !got; c++) begin
      run_cycle("contend");
      if (last_grant == 2) got = 1'b1;
      else if (last_grant >= 0) begin new_req(last_grant, 1'b0); apply(); end
    end
    compared++;
    if (!got || WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h12345678) begin
      mismatched++;
      $display("FAIL contend: got granted=%b we=%b a=%0d wd=%h expected 1 1 5 12345678",
               got, WE3, A3, WD3);
    end
  endtask

  task automatic test_idle();
    drain();
    v[0] = 1'b1; a[0] = 5'd7; d[0] = $urandom;
    apply();
    run_cycle("w7");
    run_cycle("idle");
    compared++;
    if (WE3 !== 1'b0 || A3 !== 5'd7) begin
      mismatched++;
      $display("FAIL idle: got we=%b a=%0d expected we=0 a=7", WE3, A3);
    end
    for (int i = 0; i < N; i++) new_req(i, 1'b0);
    apply();
    run_cycle("idle_ptr");
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 2) == 0) new_req(i, 1'b1);
      apply();
      run_cycle("random");
    end
  endtask

  task automatic test_reset_mid_init();
    drain();
    for (int i = 0; i < N; i++) new_req(i, 1'b0);
    apply();
    do_reset();
    check_init_seq(10);
    #3;
    RST_N = 1'b0;
    #1;
    compared++;
    if (WE3 !== 1'b0 || init_done !== 1'b0 || A3 !== 5'd0) begin
      mismatched++;
      $display("FAIL mid_reset: got we=%b done=%b a=%0d expected 0 0 0", WE3, init_done, A3);
    end
    do_reset();
    check_init_seq(32);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin v[i] = 1'b0; a[i] = '0; d[i] = '0; end
    req_valid = '0; req_addr = '0; req_data = '0;
    m_ptr = 0; m_a3 = '0; m_wd3 = '0; m_known = 1'b1; last_grant = -1;
    test_reset();
    test_init();
    test_round_robin();
    test_addr0();
    test_contention();
    test_idle();
    test_random();
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
